delay_calibrator: RTL and testbench

Measures the round-trip latency of a data path in clock cycles and computes the `sel` code that makes the path's total delay equal a requested target when a `variable_delay` line with matching `delay_min`/`sel_width` is inserted in series. On `start`, the calibrator:
- drives an idle pattern to flush the path;
- launches a single marker word;
- counts cycles until the marker returns on `rx_data`.

It sits in the comm block beside the delay lines it programs.

---
 rtl/delay_calibrator.sv | 132 +++++++++++++
 tb/tb_delay_calibrator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/delay_calibrator.sv
// Round-trip latency calibrator: flushes a data path, launches a marker word,
// times its return and derives the delay-line select that hits a target delay.
module delay_calibrator #(
  parameter int               width     = 8,
  parameter int               sel_width = 4,
  parameter int               delay_min = 24,
  parameter int               cnt_width = 8,
  parameter int               flush_len = 32,
  parameter int               max_wait  = 255,
  parameter logic [width-1:0] idle_pat  = 8'h00,
  parameter logic [width-1:0] marker    = 8'hA5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ce,
  input  logic                 start,
  input  logic [cnt_width-1:0] target,
  output logic [width-1:0]     tx_data,
  input  logic [width-1:0]     rx_data,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic [cnt_width-1:0] meas,
  output logic [sel_width-1:0] sel_out,
  output logic                 sat_hi,
  output logic                 sat_lo
);

  localparam int RW = cnt_width + 2;
  localparam logic [cnt_width-1:0] FLUSH_LAST = cnt_width'(flush_len - 1);
  localparam logic [cnt_width-1:0] WAIT_LAST  = cnt_width'(max_wait - 1);
  localparam logic [cnt_width-1:0] WAIT_MAX   = cnt_width'(max_wait);
  localparam logic signed [RW-1:0] DMIN       = RW'(delay_min);
  localparam logic signed [RW-1:0] SEL_TOP    = RW'((2 ** sel_width) - 1);

  typedef enum logic [2:0] {IDLE, FLUSH, SEND, WAIT, CALC} state_t;

  state_t                 state, state_nxt;
  logic [cnt_width-1:0]   cnt, cnt_nxt, tgt;
  logic [width-1:0]       tx_nxt;
  logic                   match, flush_end, wait_end, hit, timeout;
  logic signed [RW-1:0]   raw;

  assign match     = (rx_data == marker);
  assign flush_end = (cnt == FLUSH_LAST);
  assign wait_end  = (cnt == WAIT_LAST);
  assign raw       = $signed({2'b00, tgt}) - DMIN - $signed({2'b00, cnt});
  assign busy      = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST)     state <= IDLE;
    else if (ce) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:       if (start) state_nxt = FLUSH;
      FLUSH:      if (flush_end) state_nxt = SEND;
      SEND, WAIT: state_nxt = (match || wait_end) ? CALC : WAIT;
      CALC:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_nxt  = idle_pat;
    cnt_nxt = cnt;
    hit     = 1'b0;
    timeout = 1'b0;
    unique case (state)
      IDLE:  cnt_nxt = '0;
      FLUSH: begin
        cnt_nxt = flush_end ? '0 : cnt + 1'b1;
        if (flush_end) tx_nxt = marker;
      end
      SEND, WAIT: begin
        cnt_nxt = cnt + 1'b1;
        hit     = match;
        timeout = !match && wait_end;
      end
      CALC:    cnt_nxt = '0;
      default: cnt_nxt = '0;
    endcase
  end

  // The select is resolved on the match edge so the CALC cycle (and timeout
  // exit) presents the registered result alongside the done/fail pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_data <= idle_pat;
      cnt     <= '0;
      tgt     <= '0;
      meas    <= '0;
      sel_out <= '0;
      sat_hi  <= 1'b0;
      sat_lo  <= 1'b0;
      done    <= 1'b0;
      fail    <= 1'b0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      if (ce) begin
        tx_data <= tx_nxt;
        cnt     <= cnt_nxt;
        if (state == IDLE && start) tgt <= target;
        if (hit) begin
          meas <= cnt;
          done <= 1'b1;
          if (raw[RW-1]) begin
            sel_out <= '0;
            sat_hi  <= 1'b0;
            sat_lo  <= 1'b1;
          end else if (raw > SEL_TOP) begin
            sel_out <= '1;
            sat_hi  <= 1'b1;
            sat_lo  <= 1'b0;
          end else begin
            sel_out <= raw[sel_width-1:0];
            sat_hi  <= 1'b0;
            sat_lo  <= 1'b0;
          end
        end
        if (timeout) begin
          meas <= WAIT_MAX;
          fail <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_delay_calibrator.sv
// Directed bench for delay_calibrator: register-chain loopback of selectable
// depth, saturation, timeout, ce gating, early-marker rejection and reset.
module tb_delay_calibrator;

  localparam logic [7:0] IDLE_P = 8'h00;
  localparam logic [7:0] MARK   = 8'hA5;

  logic       CLK, RST, ce, start;
  logic [7:0] target, tx_data, rx_data, meas;
  logic       busy, done, fail, sat_hi, sat_lo;
  logic [3:0] sel_out;

  logic [7:0] pipe [0:63];
  int         depth = 30;
  logic       rx_force = 1'b0;
  logic [7:0] rx_val = IDLE_P;

  int   total = 0, passed = 0;
  int   lat, tx_first, tx_cnt;
  logic got_done, got_fail, seen;
  logic tog = 1'b0, tie = 1'b0;
  int   inj_lo = -1, inj_hi = -1, restart_n = -1;
  logic [7:0] restart_tgt = 8'd0;

  delay_calibrator dut (
    .CLK(CLK), .RST(RST), .ce(ce), .start(start), .target(target),
    .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
    .fail(fail), .meas(meas), .sel_out(sel_out), .sat_hi(sat_hi),
    .sat_lo(sat_lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Return path: ce-gated register chain, tap selected by depth.
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 64; i++) pipe[i] <= IDLE_P;
    end else if (ce) begin
      pipe[0] <= tx_data;
      for (int i = 1; i < 64; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign rx_data = rx_force ? rx_val : (depth == 0 ? tx_data : pipe[depth-1]);

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Issue start and follow the run; n counts cycles after the accepting edge.
  task automatic run_cal(input logic [7:0] tgt_v);
    lat = 0; tx_first = 0; tx_cnt = 0; got_done = 1'b0; got_fail = 1'b0;
    ce = 1'b1;
    rx_val = tie ? IDLE_P : MARK;
    rx_force = tie;
    target = tgt_v;
    start = 1'b1;
    for (int n = 1; n <= 1000; n++) begin
      step();
      if (n == 1) start = 1'b0;
      if (n == restart_n) begin
        start = 1'b1;
        target = restart_tgt;
      end else if (n == restart_n + 1) begin
        start = 1'b0;
      end
      if (tog) ce = ~ce;
      rx_force = tie || (n >= inj_lo && n <= inj_hi);
      if (tx_data == MARK) begin
        if (tx_first == 0) tx_first = n;
        tx_cnt++;
      end
      if (done || fail) begin
        lat = n;
        got_done = done;
        got_fail = fail;
        break;
      end
    end
    ce = 1'b1;
    tog = 1'b0;
    tie = 1'b0;
    rx_force = 1'b0;
    inj_lo = -1; inj_hi = -1; restart_n = -1;
  endtask

  task automatic post(input string tag);
    step();
    chk({tag, "_pulse_clear"}, int'(done | fail), 0);
    chk({tag, "_busy_fall"}, int'(busy), 0);
  endtask

  initial begin
    RST = 1'b1; ce = 1'b1; start = 1'b0; target = 8'd0;
    gap(3);
    chk("rst_tx", int'(tx_data), int'(IDLE_P));
    chk("rst_busy", int'(busy), 0);
    chk("rst_done_fail", int'({done, fail}), 0);
    chk("rst_meas", int'(meas), 0);
    chk("rst_sel", int'({sel_out, sat_hi, sat_lo}), 0);
    RST = 1'b0;
    gap(2);

    // 30-stage loopback, target 60 -> sel 6
    depth = 30;
    run_cal(8'd60);
    chk("t1_done", int'(got_done), 1);
    chk("t1_latency", lat, 64);
    chk("t1_meas", int'(meas), 30);
    chk("t1_sel", int'(sel_out), 6);
    chk("t1_sat", int'({sat_hi, sat_lo}), 0);
    chk("t1_marker_at", tx_first, 33);
    chk("t1_marker_len", tx_cnt, 1);
    post("t1");
    gap(80);

    // rx tied to idle -> timeout, select retained
    tie = 1'b1;
    run_cal(8'd60);
    chk("t2_fail", int'(got_fail), 1);
    chk("t2_no_done", int'(got_done), 0);
    chk("t2_latency", lat, 288);
    chk("t2_meas", int'(meas), 255);
    chk("t2_sel_kept", int'(sel_out), 6);
    chk("t2_sat_kept", int'({sat_hi, sat_lo}), 0);
    post("t2");
    gap(80);

    // 10-stage, target 60 -> raw 26 clamps high
    depth = 10;
    run_cal(8'd60);
    chk("t3_done", int'(got_done), 1);
    chk("t3_latency", lat, 44);
    chk("t3_meas", int'(meas), 10);
    chk("t3_sel", int'(sel_out), 15);
    chk("t3_sat", int'({sat_hi, sat_lo}), 2);
    post("t3");
    gap(80);

    // 30-stage, target 50 -> raw -4 clamps low
    depth = 30;
    run_cal(8'd50);
    chk("t4_latency", lat, 64);
    chk("t4_meas", int'(meas), 30);
    chk("t4_sel", int'(sel_out), 0);
    chk("t4_sat", int'({sat_hi, sat_lo}), 1);
    post("t4");
    gap(80);

    // ce toggling 1/0 over a gated 5-stage chain, target 35 -> sel 6
    depth = 5;
    tog = 1'b1;
    run_cal(8'd35);
    chk("t5_done", int'(got_done), 1);
    chk("t5_latency", lat, 77);
    chk("t5_meas", int'(meas), 5);
    chk("t5_sel", int'(sel_out), 6);
    chk("t5_marker_at", tx_first, 65);
    chk("t5_marker_held", tx_cnt, 2);
    post("t5");
    gap(80);

    // early marker during FLUSH plus a start pulse while busy
    depth = 12;
    inj_lo = 5; inj_hi = 8;
    restart_n = 10; restart_tgt = 8'd0;
    run_cal(8'd40);
    chk("t6_done", int'(got_done), 1);
    chk("t6_latency", lat, 46);
    chk("t6_meas", int'(meas), 12);
    chk("t6_sel", int'(sel_out), 4);
    chk("t6_sat", int'({sat_hi, sat_lo}), 0);
    post("t6");
    gap(80);

    // RST during WAIT abandons the run silently
    depth = 30;
    target = 8'd60;
    start = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      step();
      if (n == 1) start = 1'b0;
    end
    chk("t7_busy_in_wait", int'(busy), 1);
    RST = 1'b1;
    step();
    chk("t7_busy_cleared", int'(busy), 0);
    chk("t7_tx_idle", int'(tx_data), int'(IDLE_P));
    chk("t7_no_pulse_at_rst", int'({done, fail}), 0);
    chk("t7_meas_cleared", int'(meas), 0);
    chk("t7_sel_cleared", int'(sel_out), 0);
    RST = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 120; n++) begin
      step();
      if (done || fail || busy) seen = 1'b1;
    end
    chk("t7_stays_idle", int'(seen), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
